self_output_residual_add: RTL and testbench

- Stream stage between the self-output matmul engine and the LayerNorm engine.
- Takes int32 accumulators of attention_output × W_self_output, one per beat, and requantizes each with (requant_m_mm, requant_e_mm) to saturated int8.
- Adds the matching int8 residual element and emits an int16 sum stream.
- Emits per-token row statistics (sum, sum of squares), which LayerNorm uses for mean and variance.

---
 rtl/ibert_pkg.sv | 35 +++
 rtl/requant_unit.sv | 86 ++++++++
 rtl/self_output_residual_add.sv | 232 +++++++++++++++++++++++
 tb/tb_self_output_residual_add.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibert_pkg.sv
// Shared definitions for the I-BERT integer encoder stream stages.
//   TOKENS_DEF / EMBED_DEF : default run geometry (rows per run, elements per row)
//   REQUANT_E_MAX          : largest legal requantisation right-shift
//   SAT_IN_W               : width of the value handed to sat_int8
//   state_e                : run-control FSM states
//   sat_int8()             : clamp a wide signed value to [-128, 127]
package ibert_pkg;

  localparam int unsigned TOKENS_DEF    = 32;
  localparam int unsigned EMBED_DEF     = 768;
  localparam int unsigned REQUANT_E_MAX = 40;
  localparam int unsigned SAT_IN_W      = 96;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  function automatic logic signed [7:0] sat_int8(input logic signed [SAT_IN_W-1:0] v);
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = SAT_IN_W'(127);
    lo = -SAT_IN_W'(128);
    if (v > hi) begin
      return 8'sd127;
    end else if (v < lo) begin
      return -8'sd128;
    end else begin
      return $signed(v[7:0]);
    end
  endfunction

endpackage

// File: rtl/requant_unit.sv
// Two-stage requantiser: q = sat_int8(round_half_up(acc * M / 2^E)).
//   clk, rst    : clock, synchronous active-high reset
//   en          : pipeline advance enable (both stages move together)
//   in_valid    : beat present at the input this cycle
//   in_acc      : signed accumulator
//   in_tag      : side-band bits carried alongside the beat
//   m, e        : unsigned multiplier and right-shift amount (held stable by the caller)
//   out_valid   : stage-2 beat valid
//   out_q       : saturated int8 result
//   out_tag     : side-band bits aligned with out_q
//   pipe_busy   : any stage holds a valid beat
module requant_unit
  import ibert_pkg::*;
#(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned TAG_W = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [ACC_W-1:0]        in_acc,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic [31:0]             m,
  input  logic [7:0]              e,
  output logic                    out_valid,
  output logic signed [7:0]       out_q,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    pipe_busy
);

  // Signed accumulator times unsigned 32-bit multiplier.
  localparam int unsigned PW = ACC_W + 33;

  logic signed [PW-1:0]       p_d;
  logic signed [PW-1:0]       s1_p_q;
  logic                       s1_valid_q;
  logic [TAG_W-1:0]           s1_tag_q;

  logic signed [SAT_IN_W-1:0] wide;
  logic signed [SAT_IN_W-1:0] rnd;
  logic signed [SAT_IN_W-1:0] shifted;
  logic signed [7:0]          q_d;

  logic                       s2_valid_q;
  logic signed [7:0]          s2_q_q;
  logic [TAG_W-1:0]           s2_tag_q;

  // Zero-extend M so the product treats it as unsigned.
  assign p_d = $signed(in_acc) * $signed({1'b0, m});

  // Adding 2^(E-1) before an arithmetic shift rounds half toward +inf (-1.5 -> -1).
  always_comb begin
    wide    = SAT_IN_W'(s1_p_q);
    rnd     = '0;
    if (e != 8'd0) begin
      rnd = SAT_IN_W'(1) <<< (e - 8'd1);
    end
    shifted = (wide + rnd) >>> e;
    q_d     = sat_int8(shifted);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_q_q     <= '0;
      s2_tag_q   <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_p_q     <= p_d;
      s1_tag_q   <= in_tag;
      s2_valid_q <= s1_valid_q;
      s2_q_q     <= q_d;
      s2_tag_q   <= s1_tag_q;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_q     = s2_q_q;
  assign out_tag   = s2_tag_q;
  assign pipe_busy = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/self_output_residual_add.sv
// Self-output residual stage: requantises int32 matmul accumulators to int8, adds the
// int8 residual, streams int16 sums and per-row (sum, sum of squares) for LayerNorm.
//   clk, rst               : clock, synchronous active-high reset
//   start                  : run pulse, sampled only while idle
//   requant_m, requant_e   : requant multiplier / shift, latched at start
//   acc_data/valid/ready   : accumulator stream (joined with the residual stream)
//   res_data/valid/ready   : residual stream
//   out_data/last/valid/ready : residual-sum stream, last marks the row end
//   stat_sum/sumsq/valid/ready : per-row statistics
//   busy, done, error      : run status; error is sticky until the next accepted start
module self_output_residual_add
  import ibert_pkg::*;
#(
  parameter int unsigned TOKENS = TOKENS_DEF,
  parameter int unsigned EMBED  = EMBED_DEF,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SUM_W  = 24,
  parameter int unsigned SQ_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      requant_m,
  input  logic [7:0]       requant_e,
  input  logic [ACC_W-1:0] acc_data,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [7:0]       res_data,
  input  logic             res_valid,
  output logic             res_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] stat_sum,
  output logic [SQ_W-1:0]  stat_sumsq,
  output logic             stat_valid,
  input  logic             stat_ready,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned ColW = (EMBED > 1) ? $clog2(EMBED) : 1;
  localparam int unsigned RowW = (TOKENS > 1) ? $clog2(TOKENS) : 1;
  localparam int unsigned TagW = 9;  // {row_last, residual}

  state_e           state_q;
  logic [31:0]      m_q;
  logic [7:0]       e_q;
  logic [ColW-1:0]  col_q;
  logic [RowW-1:0]  row_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;

  logic             in_run;
  logic             en;
  logic             stall_stat;
  logic             join_fire;
  logic             out_fire;
  logic             col_last;
  logic             row_last;

  logic             rq_valid;
  logic signed [7:0] rq_q;
  logic [TagW-1:0]  rq_tag;
  logic             rq_busy;

  logic signed [8:0]       s_d;
  logic                    s3_valid_q;
  logic                    s3_last_q;
  logic signed [OUT_W-1:0] s3_data_q;
  logic signed [8:0]       s3_s;
  logic signed [17:0]      sq_prod;
  logic [17:0]             sq_elem;

  logic signed [SUM_W-1:0] sum_acc_q;
  logic [SQ_W-1:0]         sq_acc_q;
  logic signed [SUM_W-1:0] stat_sum_q;
  logic [SQ_W-1:0]         stat_sumsq_q;
  logic                    stat_valid_q;

  assign in_run     = (state_q == StRun);
  // A row-last beat may not leave s3 while the previous row's stats are still pending.
  assign stall_stat = s3_last_q && stat_valid_q && !stat_ready;
  assign en         = !(s3_valid_q && (!out_ready || stall_stat));

  assign acc_ready  = in_run && en && res_valid;
  assign res_ready  = in_run && en && acc_valid;
  assign join_fire  = acc_valid && acc_ready;
  // With s3 valid, en high means out_ready is high and no stat stall.
  assign out_fire   = s3_valid_q && en;

  assign col_last   = (col_q == ColW'(EMBED - 1));
  assign row_last   = (row_q == RowW'(TOKENS - 1));

  requant_unit #(
    .ACC_W (ACC_W),
    .TAG_W (TagW)
  ) u_requant (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (join_fire),
    .in_acc    (acc_data),
    .in_tag    ({col_last, res_data}),
    .m         (m_q),
    .e         (e_q),
    .out_valid (rq_valid),
    .out_q     (rq_q),
    .out_tag   (rq_tag),
    .pipe_busy (rq_busy)
  );

  // Stage 3: residual add, 9-bit signed result.
  assign s_d     = $signed({rq_q[7], rq_q}) + $signed({rq_tag[7], rq_tag[7:0]});
  assign s3_s    = $signed(s3_data_q[8:0]);
  assign sq_prod = s3_s * s3_s;
  assign sq_elem = sq_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_data_q  <= '0;
    end else if (en) begin
      s3_valid_q <= rq_valid;
      s3_last_q  <= rq_tag[8];
      s3_data_q  <= OUT_W'(s_d);
    end
  end

  // Row statistics accumulate on the out transfer; the row-last transfer publishes
  // totals including itself and restarts the accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_acc_q    <= '0;
      sq_acc_q     <= '0;
      stat_sum_q   <= '0;
      stat_sumsq_q <= '0;
      stat_valid_q <= 1'b0;
    end else begin
      if (stat_valid_q && stat_ready) begin
        stat_valid_q <= 1'b0;
      end
      if (out_fire) begin
        if (s3_last_q) begin
          stat_sum_q   <= sum_acc_q + SUM_W'(s3_data_q);
          stat_sumsq_q <= sq_acc_q + SQ_W'(sq_elem);
          stat_valid_q <= 1'b1;
          sum_acc_q    <= '0;
          sq_acc_q     <= '0;
        end else begin
          sum_acc_q    <= sum_acc_q + SUM_W'(s3_data_q);
          sq_acc_q     <= sq_acc_q + SQ_W'(sq_elem);
        end
      end
    end
  end

  // Run control with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      e_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_q    <= requant_m;
            e_q    <= requant_e;
            col_q  <= '0;
            row_q  <= '0;
            busy_q <= 1'b1;
            if (requant_e > 8'(REQUANT_E_MAX)) begin
              error_q <= 1'b1;
              state_q <= StDone;
            end else begin
              error_q <= 1'b0;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (join_fire) begin
            if (col_last) begin
              col_q <= '0;
              row_q <= row_q + RowW'(1);
              if (row_last) begin
                state_q <= StDrain;
              end
            end else begin
              col_q <= col_q + ColW'(1);
            end
          end
        end
        StDrain: begin
          if (!rq_busy && !rq_valid && !s3_valid_q && !stat_valid_q) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated so a downstream accept cannot take a row-last beat that is stalled on stats.
  assign out_valid  = s3_valid_q && !stall_stat;
  assign out_data   = s3_data_q;
  assign out_last   = s3_last_q;
  assign stat_sum   = stat_sum_q;
  assign stat_sumsq = stat_sumsq_q;
  assign stat_valid = stat_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_self_output_residual_add.sv
module tb_self_output_residual_add;

  localparam int TOKENS = 2;
  localparam int EMBED  = 768;
  localparam int N      = TOKENS * EMBED;

  logic        sim_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] requant_m = '0;
  logic [7:0]  requant_e = '0;
  logic [31:0] acc_data = '0;
  logic        acc_valid = 1'b0;
  logic        acc_ready;
  logic [7:0]  res_data = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] stat_sum;
  logic [31:0] stat_sumsq;
  logic        stat_valid;
  logic        stat_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        error;

  self_output_residual_add #(
    .TOKENS (TOKENS),
    .EMBED  (EMBED)
  ) dut (
    .clk        (sim_clk),
    .rst        (rst),
    .start      (start),
    .requant_m  (requant_m),
    .requant_e  (requant_e),
    .acc_data   (acc_data),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .stat_sum   (stat_sum),
    .stat_sumsq (stat_sumsq),
    .stat_valid (stat_valid),
    .stat_ready (stat_ready),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 sim_clk = ~sim_clk;

  int total = 0;
  int bad = 0;

  int acc_src[N];
  int res_src[N];

  longint exp_data[$];
  bit     exp_last[$];
  longint exp_sum[$];
  longint exp_sq[$];

  longint cur_m;
  int     cur_e;
  longint mdl_sum, mdl_sq;
  int     mdl_col;

  int ai, cyc, out_cnt, last_cnt, stat_cnt, done_cnt, done_cyc, outv_cnt;
  int in_drive, p_valid, p_out, p_stat, stat_hold;
  longint last_stat_sum, last_stat_sq;
  longint tbl[4];
  int     tbl_n;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint model_q(input longint acc, input longint m, input int e);
    longint p;
    p = acc * m;
    if (e > 0) p = p + (longint'(1) <<< (e - 1));
    p = p >>> e;
    if (p > 127) return 127;
    if (p < -128) return -128;
    return p;
  endfunction

  task automatic model_push(input int idx);
    longint s;
    bit     l;
    s = model_q(longint'(acc_src[idx]), cur_m, cur_e) + longint'(res_src[idx]);
    l = (mdl_col == EMBED - 1);
    exp_data.push_back(s);
    exp_last.push_back(l);
    mdl_sum += s;
    mdl_sq  += s * s;
    if (l) begin
      exp_sum.push_back(mdl_sum);
      exp_sq.push_back(mdl_sq);
      mdl_sum = 0;
      mdl_sq  = 0;
      mdl_col = 0;
    end else begin
      mdl_col++;
    end
  endtask

  task automatic cycle_step();
    bit aj, rj;
    @(negedge sim_clk);
    start = 1'b0;
    if (in_drive != 0 && ai < N) begin
      acc_data  = acc_src[ai];
      res_data  = 8'(res_src[ai]);
      acc_valid = ($urandom_range(99) < p_valid);
      res_valid = ($urandom_range(99) < p_valid);
    end else begin
      acc_valid = 1'b0;
      res_valid = 1'b0;
    end
    out_ready  = ($urandom_range(99) < p_out);
    stat_ready = (stat_hold > 0) ? 1'b0 : ($urandom_range(99) < p_stat);
    #1;
    cyc++;
    aj = acc_valid && acc_ready;
    rj = res_valid && res_ready;
    if (aj || rj) check_eq("join_sync", longint'(rj), longint'(aj));
    if (aj) begin
      model_push(ai);
      ai++;
    end
    if (out_valid) outv_cnt++;
    if (out_valid && out_ready) begin
      if (exp_data.size() == 0) begin
        check_eq("out_extra", 1, 0);
      end else begin
        if (out_cnt < tbl_n) check_eq("out_table", longint'($signed(out_data)), tbl[out_cnt]);
        check_eq("out_data", longint'($signed(out_data)), exp_data.pop_front());
        check_eq("out_last", longint'(out_last), longint'(exp_last.pop_front()));
      end
      if (out_last) last_cnt++;
      out_cnt++;
    end
    if (stat_valid) begin
      if (exp_sum.size() == 0) begin
        check_eq("stat_extra", 1, 0);
      end else begin
        check_eq("stat_sum", longint'($signed(stat_sum)), exp_sum[0]);
        check_eq("stat_sumsq", longint'(stat_sumsq), exp_sq[0]);
        if (stat_ready) begin
          void'(exp_sum.pop_front());
          void'(exp_sq.pop_front());
          stat_cnt++;
          last_stat_sum = longint'($signed(stat_sum));
          last_stat_sq  = longint'(stat_sumsq);
        end
      end
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  endtask

  task automatic begin_run(input longint m, input int e);
    exp_data.delete();
    exp_last.delete();
    exp_sum.delete();
    exp_sq.delete();
    mdl_sum = 0; mdl_sq = 0; mdl_col = 0;
    ai = 0; cyc = 0; out_cnt = 0; last_cnt = 0; stat_cnt = 0;
    done_cnt = 0; done_cyc = -1; outv_cnt = 0;
    cur_m = m;
    cur_e = e;
    @(negedge sim_clk);
    start     = 1'b1;
    requant_m = 32'(m);
    requant_e = 8'(e);
    acc_valid = 1'b0;
    res_valid = 1'b0;
  endtask

  // Full run: checks completion, counts and one done pulse.
  task automatic full_run(input string name, input longint m, input int e, input int hold_chk);
    begin_run(m, e);
    while (done_cnt == 0 && cyc < 20000) begin
      cycle_step();
      if (hold_chk != 0 && stat_hold == 1) begin
        check_eq({name, "_stall_outcnt"}, out_cnt, N - 1);
        check_eq({name, "_stall_outvalid"}, longint'(out_valid), 0);
        check_eq({name, "_stall_statcnt"}, stat_cnt, 0);
      end
      if (stat_hold > 0) stat_hold--;
    end
    check_eq({name, "_done"}, done_cnt, 1);
    check_eq({name, "_outs"}, out_cnt, N);
    check_eq({name, "_lasts"}, last_cnt, TOKENS);
    check_eq({name, "_stats"}, stat_cnt, TOKENS);
    check_eq({name, "_leftover"}, exp_data.size() + exp_sum.size(), 0);
    check_eq({name, "_error"}, longint'(error), 0);
    cycle_step();
    check_eq({name, "_done_pulse"}, longint'(done), 0);
    check_eq({name, "_idle_busy"}, longint'(busy), 0);
  endtask

  task automatic reset_outputs_zero(input string name);
    check_eq({name, "_out"}, longint'({out_valid, out_last, out_data}), 0);
    check_eq({name, "_stat"}, longint'({stat_valid, stat_sum}), 0);
    check_eq({name, "_sumsq"}, longint'(stat_sumsq), 0);
    check_eq({name, "_ctl"}, longint'({busy, done, error, acc_ready, res_ready}), 0);
  endtask

  initial begin
    in_drive = 1; p_valid = 100; p_out = 100; p_stat = 100; stat_hold = 0; tbl_n = 0;

    // Reset state
    repeat (3) @(posedge sim_clk);
    #1;
    reset_outputs_zero("reset");
    @(negedge sim_clk);
    rst = 1'b0;

    // Saturating constant run
    for (int i = 0; i < N; i++) begin
      acc_src[i] = 768;
      res_src[i] = 2;
    end
    tbl[0] = 129; tbl[1] = 129; tbl_n = 2;
    full_run("const", 64'h100, 8, 0);
    check_eq("const_sum", last_stat_sum, 99072);
    check_eq("const_sumsq", last_stat_sq, 12780288);

    // Round half up
    for (int i = 0; i < N; i++) begin
      case (i % 4)
        0: acc_src[i] = 3;
        1: acc_src[i] = -3;
        2: acc_src[i] = 1;
        default: acc_src[i] = -1;
      endcase
      res_src[i] = 0;
    end
    tbl[0] = 2; tbl[1] = -1; tbl[2] = 1; tbl[3] = 0; tbl_n = 4;
    full_run("round", 1, 1, 0);

    // Saturation both ends
    for (int i = 0; i < N; i++) begin
      acc_src[i] = (i % 2 == 0) ? -1000 : 1000;
      res_src[i] = (i % 2 == 0) ? -128 : 127;
    end
    tbl[0] = -256; tbl[1] = 254; tbl_n = 2;
    full_run("sat", 1, 0, 0);
    tbl_n = 0;

    // Random handshakes
    for (int i = 0; i < N; i++) begin
      acc_src[i] = int'($urandom_range(2000000)) - 1000000;
      res_src[i] = int'($urandom_range(255)) - 128;
    end
    p_valid = 70; p_out = 70; p_stat = 50;
    full_run("random", 64'h3579, 27, 0);

    // Stats held off across both row ends
    p_valid = 100; p_out = 100; p_stat = 100; stat_hold = N + 100;
    full_run("stathold", 64'h3579, 27, 1);

    // Illegal shift amount
    begin_run(1, 50);
    in_drive = 0;
    repeat (6) cycle_step();
    check_eq("err_flag", longint'(error), 1);
    check_eq("err_done_cyc", done_cyc, 2);
    check_eq("err_done_cnt", done_cnt, 1);
    check_eq("err_no_out", outv_cnt, 0);
    in_drive = 1;

    // Reset mid-run
    p_valid = 80; p_out = 80; p_stat = 80;
    begin_run(64'h3579, 27);
    while (ai < 1000 && cyc < 20000) cycle_step();
    check_eq("midrst_reached", ai, 1000);
    check_eq("midrst_error_cleared", longint'(error), 0);
    @(negedge sim_clk);
    rst = 1'b1;
    acc_valid = 1'b0;
    res_valid = 1'b0;
    @(posedge sim_clk);
    #1;
    reset_outputs_zero("midrst");
    @(negedge sim_clk);
    rst = 1'b0;

    // Fresh run after reset
    for (int i = 0; i < N; i++) begin
      acc_src[i] = 768;
      res_src[i] = 2;
    end
    full_run("after_rst", 64'h100, 8, 0);
    check_eq("after_rst_sum", last_stat_sum, 99072);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
